// File: rtl/score_display.sv
// score_display
//   Converts the 12-bit binary game score to four BCD digits with a
//   multi-cycle shift-and-add-3 FSM and drives a 4-digit active-low
//   common-anode 7-segment display. Digits are time-multiplexed and
//   leading zeros are blanked.
//
// Parameters
//   REFRESH_DIV : width of the free-running scan counter (>= 3). The top two
//                 bits pick the lit digit.
// Ports
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   score     : binary score 0..4095
//   an        : digit enables, active-low, an[0] = rightmost digit
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   dp        : decimal point, active-low, always off
//   bcd       : last converted value, bcd[3:0] = ones digit
//   busy      : conversion in progress
//   fsm_state : current FSM state (debug visibility)
//
// Handshake: none. score is sampled only in IDLE; changes while busy are
// picked up by the mismatch check on the next IDLE cycle.
module score_display #(
    parameter int REFRESH_DIV = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] score,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [11:0]            src;
    logic [27:0]            sh;
    logic [3:0]             cnt;
    logic [REFRESH_DIV-1:0] scan;

    // Add-3 correction of every BCD nibble before the shift.
    logic [15:0] adj;
    always_comb begin
        adj = sh[27:12];
        for (int i = 0; i < 4; i++) begin
            if (sh[12 + 4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sh[12 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM. busy is registered: it rises with the edge that
    // starts a conversion and drops on the IDLE edge that finds no new
    // work, so it also covers the cycle in which the fresh bcd appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src   <= 12'd0;
            sh    <= 28'd0;
            cnt   <= 4'd0;
            bcd   <= 16'd0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (score != src) begin
                        src   <= score;
                        sh    <= {16'd0, score};
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                CONV: begin
                    sh   <= {adj[14:0], sh[11:0], 1'b0};
                    cnt  <= cnt + 4'd1;
                    busy <= 1'b1;
                    if (cnt == 4'd11) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd   <= sh[27:12];
                    busy  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Digit selection and blanking for the current scan slot.
    logic [1:0] digit;
    logic [3:0] nib;
    logic       blank;

    assign digit = scan[REFRESH_DIV-1 -: 2];
    assign nib   = bcd[{digit, 2'b00} +: 4];

    always_comb begin
        blank = 1'b0;
        case (digit)
            2'd3: blank = (bcd[15:12] == 4'd0);
            2'd2: blank = (bcd[15:8]  == 8'd0);
            2'd1: blank = (bcd[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
    end

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0: seg_code = 7'h40;
            4'd1: seg_code = 7'h79;
            4'd2: seg_code = 7'h24;
            4'd3: seg_code = 7'h30;
            4'd4: seg_code = 7'h19;
            4'd5: seg_code = 7'h12;
            4'd6: seg_code = 7'h02;
            4'd7: seg_code = 7'h78;
            4'd8: seg_code = 7'h00;
            4'd9: seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Registered scan path: outputs lag scan/bcd by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan <= '0;
            an   <= 4'hF;
            seg  <= 7'h7F;
        end else begin
            scan <= scan + {{(REFRESH_DIV-1){1'b0}}, 1'b1};
            an   <= ~(4'b0001 << digit);
            seg  <= blank ? 7'h7F : seg_code(nib);
        end
    end

    assign dp        = 1'b1;
    assign fsm_state = state;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

    localparam int RD = 4;

    logic        clk;
    logic        rst_n;
    logic [11:0] score;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] bcd;
    logic        busy;
    logic [1:0]  fsm_state;

    int vectors;
    int miscompares;
    bit chk_en;

    score_display #(.REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score     (score),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .bcd       (bcd),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [6:0] seg_of(input int n);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (n > 9) return 7'h7F;
        return t[n];
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return 16'((v / 1000) * 4096 + ((v / 100) % 10) * 256 +
                   ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          scan_m;
    int          src_m;
    int          phase;
    logic [15:0] bcd_m;
    logic        busy_m;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_m  = 0;
            src_m   = 0;
            phase   = 0;
            bcd_m   = 16'd0;
            busy_m  = 1'b0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            int d;
            d = scan_m / (2 ** (RD - 2));
            exp_an  = 4'hF ^ (4'h1 << d);
            if (d > 0 && (bcd_m >> (4 * d)) == 16'd0) exp_seg = 7'h7F;
            else exp_seg = seg_of(int'((bcd_m >> (4 * d)) & 16'hF));
            scan_m = (scan_m + 1) % (2 ** RD);
            if (phase == 0) begin
                if (int'(score) != src_m) begin
                    src_m  = int'(score);
                    phase  = 1;
                    busy_m = 1'b1;
                end else begin
                    busy_m = 1'b0;
                end
            end else if (phase < 13) begin
                phase++;
            end else begin
                bcd_m = to_bcd(src_m);
                phase = 0;
            end
        end
    end

    // ---------------- continuous scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("an",   16'(an),   16'(exp_an));
            check("seg",  16'(seg),  16'(exp_seg));
            check("dp",   16'(dp),   16'd1);
            check("bcd",  bcd,       bcd_m);
            check("busy", 16'(busy), 16'(busy_m));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Waits for one conversion (busy rise then fall), returns busy length.
    task automatic wait_conv(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy) n++;
            else if (n > 0) break;
        end
    endtask

    // Waits for bcd to differ from prev; ok=0 on timeout.
    task automatic wait_bcd_change(input logic [15:0] prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bcd !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Captures the segment pattern shown on each digit over one full scan.
    task automatic capture_digits(output logic [27:0] got);
        got = {4{7'h55}};
        for (int i = 0; i < 2 ** RD; i++) begin
            tick();
            for (int k = 0; k < 4; k++)
                if (an == (4'hF ^ (4'h1 << k))) got[7*k +: 7] = seg;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [11:0] score;
        logic [15:0] exp_bcd;
        logic [27:0] segs;  // {d3, d2, d1, d0}
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          n;
        bit          ok;
        logic [27:0] got;

        tbl[0] = '{12'd1234, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
        tbl[1] = '{12'd4095, 16'h4095, {7'h19, 7'h40, 7'h10, 7'h12}};
        tbl[2] = '{12'd9,    16'h0009, {7'h7F, 7'h7F, 7'h7F, 7'h10}};
        tbl[3] = '{12'd1005, 16'h1005, {7'h79, 7'h40, 7'h40, 7'h12}};
        tbl[4] = '{12'd57,   16'h0057, {7'h7F, 7'h7F, 7'h12, 7'h78}};
        tbl[5] = '{12'd100,  16'h0100, {7'h7F, 7'h79, 7'h40, 7'h40}};
        tbl[6] = '{12'd0,    16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};

        vectors     = 0;
        miscompares = 0;
        chk_en      = 1'b0;
        score       = 12'd0;
        rst_n       = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;

        // Release with score 0: single "0" from the first edge, no conversion.
        rst_n = 1'b1;
        tick();
        check("post_reset_an",   16'(an),   16'hE);
        check("post_reset_seg",  16'(seg),  16'h40);
        check("post_reset_busy", 16'(busy), 16'd0);
        repeat (21) tick();
        check("idle_busy", 16'(busy), 16'd0);

        // Reset mid-scan.
        rst_n = 1'b0;
        #1;
        check("rst_an",   16'(an),   16'hF);
        check("rst_seg",  16'(seg),  16'h7F);
        check("rst_dp",   16'(dp),   16'd1);
        check("rst_bcd",  bcd,       16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Table-driven conversions.
        for (int v = 0; v < 7; v++) begin
            score = tbl[v].score;
            wait_conv(n);
            check($sformatf("tbl%0d_busy_len", v), 16'(n), 16'd14);
            check($sformatf("tbl%0d_bcd", v), bcd, tbl[v].exp_bcd);
            capture_digits(got);
            for (int k = 0; k < 4; k++)
                check($sformatf("tbl%0d_digit%0d", v, k), 16'(got[7*k +: 7]), 16'(tbl[v].segs[7*k +: 7]));
        end

        // Score change during a conversion: 100 is shown first, then 57.
        score = 12'd100;
        repeat (3) tick();
        score = 12'd57;
        wait_bcd_change(16'h0000, ok);
        check("midchg_first_seen", 16'(ok), 16'd1);
        check("midchg_first", bcd, 16'h0100);
        wait_bcd_change(16'h0100, ok);
        check("midchg_second_seen", 16'(ok), 16'd1);
        check("midchg_second", bcd, 16'h0057);
        wait_conv(n);
        repeat (5) tick();

        // Reset at shift 6 aborts; conversion of 777 restarts after release.
        score = 12'd777;
        tick();
        repeat (6) tick();
        check("midrst_busy_before", 16'(busy), 16'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd",  bcd,       16'd0);
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_an",   16'(an),   16'hF);
        check("midrst_seg",  16'(seg),  16'h7F);
        repeat (2) tick();
        rst_n = 1'b1;
        wait_conv(n);
        check("midrst_busy_len", 16'(n), 16'd14);
        check("midrst_bcd_after", bcd, 16'h0777);

        // Randomized score traffic against the model.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) score = 12'($urandom_range(0, 99));
            else score = 12'($urandom_range(0, 4095));
            repeat ($urandom_range(1, 30)) tick();
        end
        repeat (40) tick();
        check("rand_final_bcd", bcd, to_bcd(int'(score)));

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
